// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Stage-control sequencer for the 5-stage MIPS pipeline. It decides, every
//   cycle, which pipeline latches load and which load a bubble. The decision
//   is based on load-use stalls, branch redirects, instruction/data cache
//   completion and HALT. It also keeps saturating stall/redirect counters.
//
// Ports
//   CLK         system clock, rising edge
//   nRST        asynchronous active-low reset
//   ihit        instruction fetch completes this cycle
//   dhit        data access in MEM completes this cycle
//   mem_ren     MEM-stage instruction is a load
//   mem_wen     MEM-stage instruction is a store
//   lu_stall    load-use hazard request (ID depends on load in EX)
//   br_taken    branch/jump redirect resolved in EX this cycle
//   halt        HALT instruction has reached MEM/WB
//   pc_en       PC load enable
//   ifid_en     IF/ID enable        ifid_flush  bubble into IF/ID
//   idex_en     ID/EX enable        idex_flush  bubble into ID/EX
//   exmem_en    EX/MEM enable       memwb_en    MEM/WB enable
//   halted      registered, pipeline permanently stopped
//   stall_cnt   saturating count of cycles with pc_en=0 (outside HALT)
//   flush_cnt   saturating count of accepted redirects
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_ren,
  input  logic             mem_wen,
  input  logic             lu_stall,
  input  logic             br_taken,
  input  logic             halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Control vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
  //                        exmem_en, memwb_en}
  localparam logic [6:0] CTRL_NONE   = 7'b000_0000;
  localparam logic [6:0] CTRL_BRANCH = 7'b111_1111;
  localparam logic [6:0] CTRL_LUSE   = 7'b000_1111;
  localparam logic [6:0] CTRL_IMISS  = 7'b011_1011;
  localparam logic [6:0] CTRL_FLOW   = 7'b110_1011;

  state_t     stateReg;
  state_t     stateNext;
  logic       memBusy;
  logic [6:0] ctrlRaw;
  logic       brAccept;
  logic       stallEvent;

  assign memBusy = (mem_ren | mem_wen) & ~dhit;

  // Decode used whenever the MEM stage is free to advance (RUN without a
  // pending memory wait, or the completing cycle of DWAIT).
  function automatic logic [6:0] advanceCtrl(input logic brT, input logic luS,
                                             input logic ih);
    if (brT)       return CTRL_BRANCH;  // redirect squashes the stalled consumer
    else if (luS)  return CTRL_LUSE;
    else if (!ih)  return CTRL_IMISS;
    else           return CTRL_FLOW;
  endfunction

  always_comb begin
    stateNext = stateReg;
    ctrlRaw   = CTRL_NONE;
    brAccept  = 1'b0;
    case (stateReg)
      RUN: begin
        // A busy memory op must finish before HALT is honoured.
        if (halt && !memBusy) begin
          stateNext = HALT;
        end else if (memBusy) begin
          stateNext = DWAIT;
        end else begin
          ctrlRaw  = advanceCtrl(br_taken, lu_stall, ihit);
          brAccept = br_taken;
        end
      end
      DWAIT: begin
        if (dhit) begin
          stateNext = RUN;
          ctrlRaw   = advanceCtrl(br_taken, lu_stall, ihit);
          brAccept  = br_taken;
        end
      end
      HALT: begin
        stateNext = HALT;
      end
      default: begin
        stateNext = RUN;
      end
    endcase
  end

  // Outputs are gated by nRST so they drop immediately while reset is held.
  assign {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en} =
         ctrlRaw & {7{nRST}};

  assign stallEvent = ~ctrlRaw[6] & (stateReg != HALT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stateReg  <= RUN;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stateReg <= stateNext;
      halted   <= (stateNext == HALT);
      if (stallEvent && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (brAccept && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Scenario tasks plus a randomized run. The DUTs are a CNT_W=16 instance
//   and a CNT_W=2 instance, and both see the same inputs. Expected values come
//   from a rule-level model that tracks "waiting on memory" and "stopped"
//   flags and unbounded counters. Saturation is applied only when the
//   counters are compared.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ihit = 1'b0, dhit = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0;
  logic lu_stall = 1'b0, br_taken = 1'b0, halt = 1'b0;

  logic pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemEn, memwbEn, haltedB;
  logic [15:0] stallCnt, flushCnt;
  logic pcEnS, ifidEnS, ifidFlushS, idexEnS, idexFlushS, exmemEnS, memwbEnS, haltedS;
  logic [1:0] stallCntS, flushCntS;

  pipeline_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .lu_stall(lu_stall), .br_taken(br_taken), .halt(halt),
    .pc_en(pcEn), .ifid_en(ifidEn), .ifid_flush(ifidFlush), .idex_en(idexEn),
    .idex_flush(idexFlush), .exmem_en(exmemEn), .memwb_en(memwbEn),
    .halted(haltedB), .stall_cnt(stallCnt), .flush_cnt(flushCnt)
  );

  pipeline_ctrl #(.CNT_W(2)) dutSmall (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .lu_stall(lu_stall), .br_taken(br_taken), .halt(halt),
    .pc_en(pcEnS), .ifid_en(ifidEnS), .ifid_flush(ifidFlushS), .idex_en(idexEnS),
    .idex_flush(idexFlushS), .exmem_en(exmemEnS), .memwb_en(memwbEnS),
    .halted(haltedS), .stall_cnt(stallCntS), .flush_cnt(flushCntS)
  );

  always #5 CLK = ~CLK;

  int nVec = 0;
  int nErr = 0;

  // Reference model state
  bit mWait, mStopped, nxtWait, nxtStopped, brCounts;
  int mStall, mFlush;
  logic [6:0] expOut, obsOut, obsOutS;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Drive one cycle's inputs, derive the expected controls from the rules,
  // and snapshot both DUTs' controls. No comparison here.
  task automatic setInputs(input logic iIhit, input logic iDhit, input logic iRen,
                           input logic iWen, input logic iLu, input logic iBr,
                           input logic iHalt);
    bit busy;
    ihit = iIhit; dhit = iDhit; mem_ren = iRen; mem_wen = iWen;
    lu_stall = iLu; br_taken = iBr; halt = iHalt;
    #1;
    busy = (iRen || iWen) && !iDhit;
    nxtWait = mWait; nxtStopped = mStopped; brCounts = 1'b0;
    if (!nRST || mStopped)                   expOut = 7'b0000000;
    else if (mWait && !iDhit)                expOut = 7'b0000000;
    else if (!mWait && iHalt && !busy) begin expOut = 7'b0000000; nxtStopped = 1'b1; end
    else if (!mWait && busy) begin           expOut = 7'b0000000; nxtWait = 1'b1; end
    else begin
      nxtWait = 1'b0;
      if (iBr) begin    expOut = 7'b1111111; brCounts = 1'b1; end
      else if (iLu)     expOut = 7'b0001111;
      else if (!iIhit)  expOut = 7'b0111011;
      else              expOut = 7'b1101011;
    end
    obsOut  = {pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemEn, memwbEn};
    obsOutS = {pcEnS, ifidEnS, ifidFlushS, idexEnS, idexFlushS, exmemEnS, memwbEnS};
  endtask

  task automatic tick();
    @(posedge CLK);
    if (nRST) begin
      if (!expOut[6] && !mStopped) mStall++;
      if (brCounts) mFlush++;
      mWait = nxtWait;
      mStopped = nxtStopped;
    end
    #1;
  endtask

  task automatic doReset();
    nRST = 1'b0;
    ihit = 1'b0; dhit = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
    lu_stall = 1'b0; br_taken = 1'b0; halt = 1'b0;
    mWait = 0; mStopped = 0; mStall = 0; mFlush = 0;
    @(posedge CLK); #2;
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    setInputs(1, 1, 1, 1, 1, 1, 1);
    nVec++;
    if (obsOut !== 7'b0 || obsOutS !== 7'b0 || haltedB !== 1'b0 || stallCnt !== 16'd0 ||
        flushCnt !== 16'd0) begin
      nErr++;
      $display("FAIL reset_outputs: ctrl=%b ctrlS=%b halted=%b stall=%0d flush=%0d, need all 0",
               obsOut, obsOutS, haltedB, stallCnt, flushCnt);
    end
    doReset();
    $display("test_reset done");
  endtask

  task automatic test_run();
    for (int i = 0; i < 5; i++) begin
      setInputs(1, 0, 0, 0, 0, 0, 0);
      nVec++;
      if (obsOut !== 7'b1101011 || obsOutS !== expOut) begin
        nErr++;
        $display("FAIL run_ctrl cyc%0d: ctrl=%b ctrlS=%b need %b", i, obsOut, obsOutS, 7'b1101011);
      end
      tick();
    end
    nVec++;
    if (stallCnt !== 16'd0 || haltedB !== 1'b0) begin
      nErr++;
      $display("FAIL run_counters: stall=%0d halted=%b need 0 0", stallCnt, haltedB);
    end
    $display("test_run done");
  endtask

  task automatic test_lu_stall();
    int base;
    base = mStall;
    setInputs(1, 0, 0, 0, 1, 0, 0);
    nVec++;
    if (obsOut !== 7'b0001111 || obsOut !== expOut) begin
      nErr++;
      $display("FAIL lu_stall_ctrl: ctrl=%b need %b", obsOut, 7'b0001111);
    end
    tick();
    nVec++;
    if (stallCnt !== 16'(base + 1)) begin
      nErr++;
      $display("FAIL lu_stall_cnt: stall=%0d need %0d", stallCnt, base + 1);
    end
    setInputs(1, 0, 0, 0, 0, 0, 0);
    nVec++;
    if (obsOut !== 7'b1101011) begin
      nErr++;
      $display("FAIL lu_stall_resume: ctrl=%b need %b", obsOut, 7'b1101011);
    end
    tick();
    $display("test_lu_stall done");
  endtask

  task automatic test_dwait();
    int base;
    base = mStall;
    for (int i = 0; i < 3; i++) begin
      setInputs(1, 0, 1, 0, 0, 0, 0);
      nVec++;
      if (obsOut !== 7'b0 || obsOut !== expOut) begin
        nErr++;
        $display("FAIL dwait_hold cyc%0d: ctrl=%b need %b", i, obsOut, 7'b0);
      end
      tick();
    end
    setInputs(1, 1, 1, 0, 0, 0, 0);
    nVec++;
    if (obsOut !== 7'b1101011) begin
      nErr++;
      $display("FAIL dwait_release: ctrl=%b need %b", obsOut, 7'b1101011);
    end
    tick();
    nVec++;
    if (stallCnt !== 16'(base + 3)) begin
      nErr++;
      $display("FAIL dwait_cnt: stall=%0d need %0d", stallCnt, base + 3);
    end
    // Back in RUN: a fresh cycle without memory traffic advances normally.
    setInputs(1, 0, 0, 0, 0, 0, 0);
    nVec++;
    if (obsOut !== 7'b1101011) begin
      nErr++;
      $display("FAIL dwait_back_to_run: ctrl=%b need %b", obsOut, 7'b1101011);
    end
    tick();
    $display("test_dwait done");
  endtask

  task automatic test_branch_over_stall();
    int sBase, fBase;
    sBase = mStall; fBase = mFlush;
    setInputs(1, 0, 0, 0, 1, 1, 0);
    nVec++;
    if (obsOut !== 7'b1111111) begin
      nErr++;
      $display("FAIL br_over_lu_ctrl: ctrl=%b need %b", obsOut, 7'b1111111);
    end
    tick();
    nVec++;
    if (flushCnt !== 16'(fBase + 1) || stallCnt !== 16'(sBase)) begin
      nErr++;
      $display("FAIL br_over_lu_cnt: flush=%0d stall=%0d need %0d %0d",
               flushCnt, stallCnt, fBase + 1, sBase);
    end
    $display("test_branch_over_stall done");
  endtask

  task automatic test_halt();
    // halt with a busy store: wait for memory first
    setInputs(1, 0, 0, 1, 0, 0, 1);
    nVec++;
    if (obsOut !== 7'b0) begin
      nErr++;
      $display("FAIL halt_busy_ctrl: ctrl=%b need 0", obsOut);
    end
    tick();
    nVec++;
    if (haltedB !== 1'b0) begin
      nErr++;
      $display("FAIL halt_busy_not_halted: halted=%b need 0", haltedB);
    end
    // dhit arrives; halt is ignored in the waiting state
    setInputs(1, 1, 0, 1, 0, 0, 1);
    nVec++;
    if (obsOut !== 7'b1101011) begin
      nErr++;
      $display("FAIL halt_dwait_release: ctrl=%b need %b", obsOut, 7'b1101011);
    end
    tick();
    setInputs(1, 0, 0, 0, 0, 0, 1);
    nVec++;
    if (obsOut !== 7'b0 || haltedB !== 1'b0) begin
      nErr++;
      $display("FAIL halt_enter: ctrl=%b halted=%b need 0 0", obsOut, haltedB);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      setInputs(i[0], 1, 0, 0, 1, 1, 0);
      nVec++;
      if (haltedB !== 1'b1 || obsOut !== 7'b0 || stallCnt !== 16'(mStall) ||
          flushCnt !== 16'(mFlush)) begin
        nErr++;
        $display("FAIL halt_sticky cyc%0d: halted=%b ctrl=%b stall=%0d flush=%0d need 1 0 %0d %0d",
                 i, haltedB, obsOut, stallCnt, flushCnt, mStall, mFlush);
      end
      tick();
    end
    doReset();
    #1;
    nVec++;
    if (haltedB !== 1'b0 || stallCnt !== 16'd0 || flushCnt !== 16'd0) begin
      nErr++;
      $display("FAIL halt_reset_clear: halted=%b stall=%0d flush=%0d need 0 0 0",
               haltedB, stallCnt, flushCnt);
    end
    $display("test_halt done");
  endtask

  task automatic test_saturation();
    doReset();
    for (int i = 0; i < 6; i++) begin
      setInputs(0, 0, 0, 0, 0, 0, 0);
      tick();
      nVec++;
      if (stallCntS !== 2'(sat(i + 1, 3)) || stallCnt !== 16'(i + 1)) begin
        nErr++;
        $display("FAIL sat_stall cyc%0d: small=%0d wide=%0d need %0d %0d",
                 i, stallCntS, stallCnt, sat(i + 1, 3), i + 1);
      end
    end
    $display("test_saturation done");
  endtask

  task automatic test_reset_mid_dwait();
    setInputs(1, 0, 1, 0, 0, 0, 0);
    tick();
    setInputs(1, 1, 0, 0, 0, 1, 0);  // would advance if in the waiting state
    #2;
    nRST = 1'b0;
    #1;
    obsOut = {pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemEn, memwbEn};
    nVec++;
    if (obsOut !== 7'b0 || stallCnt !== 16'd0) begin
      nErr++;
      $display("FAIL reset_async: ctrl=%b stall=%0d need 0 0", obsOut, stallCnt);
    end
    mWait = 0; mStopped = 0; mStall = 0; mFlush = 0;
    @(posedge CLK); #2;
    nRST = 1'b1;
    // dhit=0 with no memory op: RUN advances, a lingering wait would not
    setInputs(1, 0, 0, 0, 0, 0, 0);
    nVec++;
    if (obsOut !== 7'b1101011) begin
      nErr++;
      $display("FAIL reset_to_run: ctrl=%b need %b", obsOut, 7'b1101011);
    end
    tick();
    $display("test_reset_mid_dwait done");
  endtask

  task automatic test_random();
    int stoppedFor;
    stoppedFor = 0;
    for (int i = 0; i < 600; i++) begin
      if (stoppedFor > 3 || $urandom_range(0, 199) == 0) begin
        doReset();
        stoppedFor = 0;
      end
      setInputs($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1,
                $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 3);
      nVec++;
      if (obsOut !== expOut || obsOutS !== expOut) begin
        nErr++;
        $display("FAIL rand_ctrl cyc%0d: ctrl=%b ctrlS=%b need %b", i, obsOut, obsOutS, expOut);
      end
      tick();
      nVec++;
      if (stallCnt !== 16'(sat(mStall, 65535)) || flushCnt !== 16'(sat(mFlush, 65535)) ||
          stallCntS !== 2'(sat(mStall, 3)) || flushCntS !== 2'(sat(mFlush, 3)) ||
          haltedB !== mStopped || haltedS !== mStopped) begin
        nErr++;
        $display("FAIL rand_state cyc%0d: stall=%0d/%0d flush=%0d/%0d halted=%b/%b need %0d/%0d %0d/%0d %b",
                 i, stallCnt, stallCntS, flushCnt, flushCntS, haltedB, haltedS,
                 sat(mStall, 65535), sat(mStall, 3), sat(mFlush, 65535), sat(mFlush, 3), mStopped);
      end
      if (mStopped) stoppedFor++;
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_run();
    test_lu_stall();
    test_dwait();
    test_branch_over_stall();
    test_halt();
    test_saturation();
    test_reset_mid_dwait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
